// File: rtl/display_cal.sv
// Binary-to-BCD display driver: iterative double-dabble conversion feeding a
// time-multiplexed, active-low 7-segment display with blanking and overflow dashes.
module display_cal #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       value,
    input  logic              load,
    input  logic              blank_lz,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + 32;
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    function automatic logic [31:0] max_val(input int d);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < d; i++) p = p * 64'd10;
        return 32'(p - 64'd1);
    endfunction

    localparam logic [31:0] MAX_VAL = max_val(DIGITS);

    // One double-dabble iteration: correct every BCD nibble, then shift left.
    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] r);
        logic [SR_W-1:0] t;
        t = r;
        for (int n = 0; n < DIGITS; n++) begin
            if (t[32 + 4*n +: 4] >= 4'd5)
                t[32 + 4*n +: 4] = t[32 + 4*n +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state, state_next;
    logic              accept, ovf_load, done;
    logic [5:0]        cnt;
    logic [SR_W-1:0]   sr;
    logic [BCD_W-1:0]  disp;
    logic [DW-1:0]     div;
    logic [IW-1:0]     idx;
    logic [DIGITS-1:0] lz;
    logic              zero_above;
    logic [3:0]        dig;
    logic              dig_lz;
    logic [6:0]        seg_next;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ovf_load   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    if (value > MAX_VAL) begin
                        ovf_load = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = CONV;
                    end
                end
            end
            CONV: begin
                if (cnt == 6'd32) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath: capture on accept, then one shift per clock.
    always_ff @(posedge clk) begin
        if (accept)
            sr <= {{BCD_W{1'b0}}, value};
        else if (state == CONV && !done)
            sr <= dabble(sr);
    end

    // busy lags the state by one edge so it covers exactly the 32 shift edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 6'd0;
            busy <= 1'b0;
            ovf  <= 1'b0;
            disp <= '0;
        end else begin
            busy <= (state == CONV) && !done;
            if (accept)
                cnt <= 6'd0;
            else if (state == CONV && !done)
                cnt <= cnt + 6'd1;
            if (ovf_load)
                ovf <= 1'b1;
            if (done) begin
                ovf  <= 1'b0;
                disp <= sr[SR_W-1 -: BCD_W];
            end
        end
    end

    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp[4*i +: 4] == 4'd0);
            lz[i]      = zero_above && (i != 0);
        end
    end

    always_comb begin
        dig    = 4'd0;
        dig_lz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                dig    = disp[4*i +: 4];
                dig_lz = lz[i];
            end
        end
        if (ovf)
            seg_next = 7'h3F;
        else if (blank_lz && dig_lz)
            seg_next = 7'h7F;
        else
            seg_next = seg_code(dig);
    end

    // Scan stage: seg/an registered one cycle behind the scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
            seg <= 7'h7F;
            an  <= '1;
        end else begin
            if (div == DW'(SCAN_DIV - 1)) begin
                div <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
            an  <= ~(DIGITS'(1) << idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_display_cal.sv
// Bench for display_cal: table of load vectors checked through a scoreboard,
// plus hand sequences for reset, blanking toggle, ignored load and abort.
module tb_display_cal;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic        load;
    logic        blank_lz;
    logic        busy;
    logic        ovf;
    logic [6:0]  seg;
    logic [3:0]  an;

    always #5 clk = ~clk;

    display_cal #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
        .busy(busy), .ovf(ovf), .seg(seg), .an(an)
    );

    typedef struct {
        logic [31:0]     value;
        logic            lz;
        logic            exp_ovf;
        logic [3:0][6:0] exp_seg;
    } vec_t;

    vec_t vecs[11];
    vec_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic [31:0] v, input logic lz, input logic o,
                                input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0);
        vec_t r;
        r.value   = v;
        r.lz      = lz;
        r.exp_ovf = o;
        r.exp_seg = {s3, s2, s1, s0};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_load(input logic [31:0] v, input logic lz);
        @(negedge clk);
        value    = v;
        blank_lz = lz;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
        value = $urandom;
    endtask

    // Samples busy after edges N..N+34 of a load accepted at edge N.
    task automatic busy_watch(input int pulse_at, input logic [31:0] pulse_val,
                              output int busy_cnt, output logic ovf_first);
        busy_cnt  = 0;
        ovf_first = 1'b0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (busy) busy_cnt++;
            if (k == 0) ovf_first = ovf;
            if (k == pulse_at) begin
                value = pulse_val;
                load  = 1'b1;
            end
        end
        load = 1'b0;
    endtask

    task automatic check_display(input logic [3:0][6:0] exp, input logic exp_ovf, input int tag);
        logic [6:0] seen[4];
        int bad_onehot;
        bad_onehot = 0;
        for (int d = 0; d < 4; d++) seen[d] = 7'bx;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: seen[0] = seg;
                4'b1101: seen[1] = seg;
                4'b1011: seen[2] = seg;
                4'b0111: seen[3] = seg;
                default: bad_onehot++;
            endcase
        end
        check($sformatf("t%0d an_onehot_errors", tag), 32'(bad_onehot), 32'd0);
        check($sformatf("t%0d ovf", tag), {31'd0, ovf}, {31'd0, exp_ovf});
        for (int d = 0; d < 4; d++)
            check($sformatf("t%0d seg_digit%0d", tag, d), {25'd0, seen[d]}, {25'd0, exp[d]});
    endtask

    task automatic run_vec(input vec_t v, input int tag, input int pulse_at,
                           input logic [31:0] pulse_val);
        vec_t e;
        int   bc;
        logic of;
        start_load(v.value, v.lz);
        sb.push_back(v);
        busy_watch(pulse_at, pulse_val, bc, of);
        e = sb.pop_front();
        check($sformatf("t%0d busy_cycles", tag), 32'(bc), e.exp_ovf ? 32'd0 : 32'd32);
        if (e.exp_ovf)
            check($sformatf("t%0d ovf_next_cycle", tag), {31'd0, of}, 32'd1);
        check_display(e.exp_seg, e.exp_ovf, tag);
    endtask

    initial begin
        int bc;
        logic of;

        vecs[0]  = mk(32'd1234,  1'b0, 1'b0, 7'h79, 7'h24, 7'h30, 7'h19);
        vecs[1]  = mk(32'd7,     1'b1, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h78);
        vecs[2]  = mk(32'd10000, 1'b0, 1'b1, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        vecs[3]  = mk(32'd9999,  1'b0, 1'b0, 7'h10, 7'h10, 7'h10, 7'h10);
        vecs[4]  = mk(32'd0,     1'b1, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h40);
        vecs[5]  = mk(32'd1005,  1'b1, 1'b0, 7'h79, 7'h40, 7'h40, 7'h12);
        vecs[6]  = mk(32'd50,    1'b1, 1'b0, 7'h7F, 7'h7F, 7'h12, 7'h40);
        vecs[7]  = mk(32'd10000, 1'b1, 1'b1, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        vecs[8]  = mk(32'd86,    1'b0, 1'b0, 7'h40, 7'h40, 7'h00, 7'h02);
        vecs[9]  = mk(32'hFFFF_FFFF, 1'b0, 1'b1, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        vecs[10] = mk(32'd5678,  1'b0, 1'b0, 7'h12, 7'h02, 7'h78, 7'h00);

        rst = 1'b1; load = 1'b0; blank_lz = 1'b0; value = 32'd0;
        repeat (3) @(negedge clk);
        check("reset seg", {25'd0, seg}, 32'h7F);
        check("reset an", {28'd0, an}, 32'hF);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset ovf", {31'd0, ovf}, 32'd0);

        // Scan order after release: 4 cycles per digit, wrapping back to digit 0.
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] ea;
            @(negedge clk);
            ea = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("scan an k%0d", k), {28'd0, an}, {28'd0, ea});
            check($sformatf("scan seg k%0d", k), {25'd0, seg}, 32'h40);
        end

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i, -1, 32'd0);
            if (i == 1) begin
                @(negedge clk);
                blank_lz = 1'b0;
                check_display({7'h40, 7'h40, 7'h40, 7'h78}, 1'b0, 100);
            end
        end

        // Second load at busy cycle 10 must be dropped.
        run_vec(vecs[0], 200, 10, 32'd5678);

        // Reset at busy cycle 15 abandons the conversion.
        start_load(32'd4321, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 15) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort ovf", {31'd0, ovf}, 32'd0);
        check_display({7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, 300);
        repeat (30) @(negedge clk);
        check_display({7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, 301);

        // rst and load in the same cycle: reset wins.
        @(negedge clk);
        rst = 1'b1; load = 1'b1; value = 32'd1234;
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        check("rst_load busy", {31'd0, busy}, 32'd0);
        busy_watch(-1, 32'd0, bc, of);
        check("rst_load busy_cycles", 32'(bc), 32'd0);
        check_display({7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, 400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_cal.md
Name: display_cal

Overview:
- Output-side counterpart of the calculator's keypad operand reader.
- Takes a 32-bit binary result and converts it to BCD with an iterative double-dabble engine (one shift per clock).
- Drives a time-multiplexed, active-low 7-segment display with leading-zero blanking and overflow dashes.
- Sits between the arithmetic unit and the board's seven-segment pins.

Parameters:
- DIGITS, 4, number of displayed decimal digits (supported range 1..8).
- SCAN_DIV, 50000, clk cycles each digit stays enabled before the scan advances (minimum 1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  32  unsigned binary result to display; sampled only on an accepted load.
- load  input  1  request to convert and display value; accepted only when busy=0.
- blank_lz  input  1  1 = blank leading zeros; sampled continuously.
- busy  output  1  high while a conversion is in progress.
- ovf  output  1  high while the shown value exceeds 10^DIGITS-1.
- seg  output  7  {g,f,e,d,c,b,a}, active-low segments.
- an  output  DIGITS  active-low digit enables, one-hot-low; an[0] is the least significant digit.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - busy=0, ovf=0, displayed digits all 0.
  - Scan index 0, divider 0.
  - seg=7'h7F, an=all ones.
  - Any in-flight conversion is abandoned and the display shows 0.
- FSM states:
  - IDLE --(load & value<=10^DIGITS-1)--> CONV.
  - IDLE --(load & value>10^DIGITS-1)--> IDLE, with ovf<=1 and the display set to all dashes next cycle.
  - CONV --(32nd shift done)--> IDLE.
- Load timing:
  - A load accepted at edge N captures value; busy=1 from N+1 through N+32.
  - At edge N+33: busy=0, ovf=0, and the new BCD digits are copied to the display register.
  - Latency from load to new digits is exactly 33 cycles, independent of value.
  - In the overflow case busy stays 0 and the dashes appear after edge N+1.
- Load while busy=1 is ignored; no queueing.
- Double-dabble conversion:
  - Shift register holds 4*DIGITS BCD bits plus the 32 binary bits; exactly 32 iterations.
  - Each cycle, every BCD nibble >=5 gets +3, then the whole register shifts left by 1 in the same cycle.
- The display register holds the previous result during CONV; no partial digits are ever shown.
- Scan:
  - The divider counts 0..SCAN_DIV-1. On wrap, the scan index increments and wraps DIGITS-1 -> 0.
  - seg and an are registered: they reflect the scan index one cycle after it changes.
  - Exactly one an bit is low at any time outside reset.
- Leading-zero blanking (blank_lz=1):
  - Digit i is blanked (seg=7'h7F, an still driven low) if it and every digit above it are 0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - Blanking is ignored when ovf=1.
- Segment codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, dash=3F, blank=7F (hex).
- Simultaneous rst and load: rst wins.
- value changing after acceptance has no effect.

Test Plan:
- Reset, then release rst with SCAN_DIV=4, DIGITS=4 -> cycle 1 after release: an=4'b1110, seg=7'h40; an advances every 4 cycles through 1101, 1011, 0111, then wraps to 1110.
- load with value=1234, blank_lz=0 -> busy high exactly 32 cycles; at the 33rd edge the digits read 4,3,2,1 from an[0] to an[3]; seg codes 19, 30, 24, 79.
- value=7, blank_lz=1 -> an[0] shows seg=78; an[1..3] show 7F. Toggle blank_lz=0 -> those digits show 40.
- value=10000 -> ovf=1 one cycle later, busy never rises, all digits show 3F. Then load value=9999 -> ovf clears at completion and all digits show 10.
- Pulse load again at busy cycle 10 with a different value -> ignored; the first value is displayed.
- Assert rst at busy cycle 15 -> busy=0 and digits 0 next cycle; the old value never appears.
